// File: rtl/sonar_scan_sequencer.sv
// Trigger scheduler for N_CH ultrasonic rangers. Fires enabled channels in
// ascending index order: an active trigger window of ACT_SLOTS slots, then a
// quiet window of PAUSE_SLOTS slots, one slot being slot_len+1 clocks.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start                   1-cycle pulse, begins a frame from IDLE
//   continuous              level, restarts the frame automatically at frame end
//   abort                   synchronous, forces IDLE on the next cycle
//   ch_mask, slot_len       channel enables and slot period-1, latched per frame
//   trig                    one-hot trigger, high only while ACTIVE
//   ch_idx                  index of the current channel
//   busy                    high in ACTIVE or PAUSE
//   ch_start                pulse on the first cycle of each ACTIVE window
//   frame_done              pulse on the last cycle of the final PAUSE
module sonar_scan_sequencer #(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ACT_SLOTS   = 3,
  parameter int unsigned PAUSE_SLOTS = 3,
  parameter int unsigned IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [N_CH-1:0]  ch_mask,
  input  logic [CNT_W-1:0] slot_len,
  output logic [N_CH-1:0]  trig,
  output logic [IDX_W-1:0] ch_idx,
  output logic             busy,
  output logic             ch_start,
  output logic             frame_done
);

  localparam int unsigned MAX_SLOTS = (ACT_SLOTS > PAUSE_SLOTS) ? ACT_SLOTS : PAUSE_SLOTS;
  localparam int unsigned SLOT_W    = $clog2(MAX_SLOTS + 1);
  localparam logic [SLOT_W-1:0] ACT_LAST   = SLOT_W'(ACT_SLOTS - 1);
  localparam logic [SLOT_W-1:0] PAUSE_LAST = SLOT_W'(PAUSE_SLOTS - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  presc, nxt_presc;
  logic [SLOT_W-1:0] slot_cnt, nxt_slot;
  logic [IDX_W-1:0]  nxt_idx;
  logic [N_CH-1:0]   mask_q, nxt_mask;
  logic [CNT_W-1:0]  slot_len_q, nxt_len;
  logic              tick;

  // Lowest set bit of a mask (0 when empty).
  function automatic logic [IDX_W-1:0] lowest(input logic [N_CH-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--)
      if (m[i]) r = IDX_W'(i);
    return r;
  endfunction

  // Any set bit above the current channel.
  function automatic logic higher_any(input logic [N_CH-1:0] m, input logic [IDX_W-1:0] cur);
    logic f;
    f = 1'b0;
    for (int i = 0; i < int'(N_CH); i++)
      if (m[i] && (i > int'(cur))) f = 1'b1;
    return f;
  endfunction

  // Nearest set bit above the current channel.
  function automatic logic [IDX_W-1:0] next_higher(input logic [N_CH-1:0] m, input logic [IDX_W-1:0] cur);
    logic [IDX_W-1:0] r;
    r = cur;
    for (int i = int'(N_CH) - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) r = IDX_W'(i);
    return r;
  endfunction

  assign tick = (presc == slot_len_q);

  // Next-state and counter logic; outputs are registered from these values.
  always_comb begin
    nxt_state = state;
    nxt_presc = tick ? '0 : presc + CNT_W'(1);
    nxt_slot  = slot_cnt;
    nxt_idx   = ch_idx;
    nxt_mask  = mask_q;
    nxt_len   = slot_len_q;
    unique case (state)
      IDLE: begin
        nxt_presc = '0;
        nxt_slot  = '0;
        nxt_idx   = '0;
        if (start) begin
          nxt_mask = ch_mask;
          nxt_len  = slot_len;
          if (ch_mask != '0) begin
            nxt_state = ACTIVE;
            nxt_idx   = lowest(ch_mask);
          end
        end
      end
      ACTIVE: begin
        if (tick) begin
          if (slot_cnt == ACT_LAST) begin
            nxt_state = PAUSE;
            nxt_slot  = '0;
          end else begin
            nxt_slot = slot_cnt + SLOT_W'(1);
          end
        end
      end
      PAUSE: begin
        if (tick) begin
          if (slot_cnt == PAUSE_LAST) begin
            nxt_slot  = '0;
            nxt_presc = '0;
            if (higher_any(mask_q, ch_idx)) begin
              nxt_state = ACTIVE;
              nxt_idx   = next_higher(mask_q, ch_idx);
            end else if (continuous && (ch_mask != '0)) begin
              nxt_mask  = ch_mask;
              nxt_len   = slot_len;
              nxt_state = ACTIVE;
              nxt_idx   = lowest(ch_mask);
            end else begin
              if (continuous) begin
                nxt_mask = ch_mask;
                nxt_len  = slot_len;
              end
              nxt_state = IDLE;
              nxt_idx   = '0;
            end
          end else begin
            nxt_slot = slot_cnt + SLOT_W'(1);
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
    if (abort) begin
      nxt_state = IDLE;
      nxt_presc = '0;
      nxt_slot  = '0;
      nxt_idx   = '0;
    end
  end

  // State, counters and look-ahead registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      presc      <= '0;
      slot_cnt   <= '0;
      ch_idx     <= '0;
      mask_q     <= '0;
      slot_len_q <= '0;
      trig       <= '0;
      busy       <= 1'b0;
      ch_start   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      presc      <= nxt_presc;
      slot_cnt   <= nxt_slot;
      ch_idx     <= nxt_idx;
      mask_q     <= nxt_mask;
      slot_len_q <= nxt_len;
      trig       <= (nxt_state == ACTIVE) ? (N_CH'(1) << nxt_idx) : '0;
      busy       <= (nxt_state != IDLE);
      ch_start   <= (nxt_state == ACTIVE) && (state != ACTIVE);
      // Flag the cycle that will be the last of the frame's final pause.
      frame_done <= (nxt_state == PAUSE) && (nxt_slot == PAUSE_LAST) &&
                    (nxt_presc == nxt_len) && !higher_any(nxt_mask, nxt_idx);
    end
  end

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// Directed bench for sonar_scan_sequencer with default parameters.
module tb_sonar_scan_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [2:0]  ch_mask;
  logic [31:0] slot_len;
  logic [2:0]  trig;
  logic [1:0]  ch_idx;
  logic        busy;
  logic        ch_start;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  sonar_scan_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
    .abort(abort), .ch_mask(ch_mask), .slot_len(slot_len), .trig(trig),
    .ch_idx(ch_idx), .busy(busy), .ch_start(ch_start), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {trig, ch_idx, busy, ch_start, frame_done}
  function automatic logic [7:0] obs();
    return {trig, ch_idx, busy, ch_start, frame_done};
  endfunction

  // Expected outputs k cycles after the start pulse for nfr back-to-back frames.
  function automatic logic [7:0] expv(int k, logic [2:0] m, int len, int nfr);
    int w, seg, kc, pos, p, j, cnt, ch, off;
    logic [2:0] tr;
    w = 3 * (len + 1);
    seg = 2 * w;
    kc = 0;
    for (int i = 0; i < 3; i++) if (m[i]) kc++;
    pos = k - 1;
    if (kc == 0 || pos < 0 || pos >= nfr * kc * seg) return 8'h00;
    p = pos % (kc * seg);
    j = p / seg;
    cnt = 0;
    ch = 0;
    for (int i = 0; i < 3; i++) if (m[i]) begin
      if (cnt == j) ch = i;
      cnt++;
    end
    off = p % seg;
    tr = (off < w) ? 3'(1 << ch) : 3'b000;
    return {tr, 2'(ch), 1'b1, (off == 0), (p == kc * seg - 1)};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, o, e);
  endtask

  // Start a frame, then check ncyc cycles; optionally re-pulse start (with
  // altered mask/slot_len) at again_k and drop continuous at contoff_k.
  task automatic run_frame(input string tag, input logic [2:0] m, input int len,
                           input int nfr, input int ncyc, input int again_k,
                           input int contoff_k);
    ch_mask  = m;
    slot_len = 32'(len);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      chk($sformatf("%s k=%0d", tag, k), obs(), expv(k, m, len, nfr));
      start = 1'b0;
      if (k == again_k) begin
        start    = 1'b1;
        ch_mask  = ~m;
        slot_len = 32'd7;
      end
      if (k == contoff_k) continuous = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    abort      = 1'b0;
    ch_mask    = 3'b000;
    slot_len   = 32'd0;
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", obs(), 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", obs(), 8'h00);

    // Full three-channel frame, slot_len=4.
    run_frame("s1", 3'b111, 4, 1, 95, 0, 0);

    // Channel 1 disabled, one-clock slots.
    run_frame("s2", 3'b101, 0, 1, 14, 0, 0);

    // Continuous frames on channel 1, then stop after the third frame.
    continuous = 1'b1;
    run_frame("s3", 3'b010, 1, 3, 40, 0, 30);

    // Abort in the second active window, then restart from channel 0.
    run_frame("s4a", 3'b111, 4, 1, 35, 0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("s4 abort k=%0d", k), obs(), 8'h00);
      @(negedge clk);
    end
    run_frame("s4b", 3'b111, 0, 1, 20, 0, 0);

    // Empty mask, start while busy, abort together with start.
    run_frame("s5a", 3'b000, 2, 1, 4, 0, 0);
    run_frame("s5b", 3'b101, 0, 1, 14, 5, 0);
    ch_mask = 3'b111;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("s5c k=%0d", k), obs(), 8'h00);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges mid-ACTIVE.
    run_frame("s6a", 3'b111, 4, 1, 5, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk("s6 async reset", obs(), 8'h00);
    @(negedge clk);
    chk("s6 held reset", obs(), 8'h00);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("s6 idle k=%0d", k), obs(), 8'h00);
    end
    run_frame("s6b", 3'b111, 0, 1, 20, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
